// File: rtl/cpu_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select codes, scoreboard slots,
// and the hit qualifier for hz_match. Zero latency (types only); no backpressure.
package cpu_pkg;

  localparam int REG_AW_P = 3;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef enum logic [1:0] {Q_ANY, Q_LOAD, Q_NONLOAD} hz_qual_e;

  typedef struct packed {
    logic                vld;
    logic [REG_AW_P-1:0] rd;
    logic                regwrite;
    logic                memread;
  } slot_t;

  typedef struct packed {
    slot_t               base;
    logic [REG_AW_P-1:0] rs1;
    logic [REG_AW_P-1:0] rs2;
    logic                use1;
    logic                use2;
  } ex_slot_t;

  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_REG);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side inputs and stall/flush/forward outputs of the hazard controller.
// Pure wiring, zero latency; no handshake (controls are level signals every cycle).
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_branch;
  logic              jump;
  logic              mem_busy;

  logic              stall_fd;
  logic              bubble_ex;
  logic              flush_d;
  logic              freeze;
  logic [1:0]        fwd1_ex;
  logic [1:0]        fwd2_ex;
  logic [1:0]        bfwd1;
  logic [1:0]        bfwd2;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_branch, jump, mem_busy,
    input  stall_fd, bubble_ex, flush_d, freeze, fwd1_ex, fwd2_ex,
           bfwd1, bfwd2, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_branch, jump, mem_busy,
    output stall_fd, bubble_ex, flush_d, freeze, fwd1_ex, fwd2_ex,
           bfwd1, bfwd2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_hz_match.sv
// hz_match: does a scoreboard slot write register i_reg (optionally only loads / only non-loads).
// Combinational, zero latency; no backpressure.
module hz_match
  import cpu_pkg::*;
#(
  parameter hz_qual_e QUAL = Q_ANY
) (
  input  slot_t               i_slot,
  input  logic [REG_AW_P-1:0] i_reg,
  output logic                o_hit
);
  logic w_wr;

  assign w_wr = i_slot.vld & i_slot.regwrite & (i_slot.rd == i_reg);

  always_comb begin
    o_hit = w_wr;
    case (QUAL)
      Q_LOAD:    o_hit = w_wr & i_slot.memread;
      Q_NONLOAD: o_hit = w_wr & ~i_slot.memread;
      default:   o_hit = w_wr;
    endcase
  end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Scoreboarded hazard/forward controller: EX/MEM/WB slots drive forwards, stalls, flush; HAZARD_PERF_EN adds counters.
// Outputs are combinational (0-cycle) from slots + decode; mem_busy freezes all slots and masks stall/flush.
module hazard_fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_P,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  hazard_fwd_ctrl_if.slave bus
);
  ex_slot_t          r_ex;
  ex_slot_t          w_id_slot;
  slot_t             r_mem;
  slot_t             r_wb;
  logic [REG_AW-1:0] w_id_rs [2];
  logic [REG_AW-1:0] w_ex_rs [2];
  logic [1:0]        w_id_use;
  logic [1:0]        w_ex_use;
  logic [1:0]        w_id_ex_any, w_id_ex_ld, w_id_mem_ld, w_id_mem_nl, w_id_wb;
  logic [1:0]        w_ex_mem_nl, w_ex_wb;
  fwd_sel_t          w_fwd_ex [2];
  fwd_sel_t          w_bfwd [2];
  logic              w_ld_stall, w_br_stall, w_stall;

  assign w_id_rs[0] = bus.id_rs1;
  assign w_id_rs[1] = bus.id_rs2;
  assign w_ex_rs[0] = r_ex.rs1;
  assign w_ex_rs[1] = r_ex.rs2;
  assign w_id_use   = {bus.id_use_rs2, bus.id_use_rs1};
  assign w_ex_use   = {r_ex.use2, r_ex.use1};

  for (genvar i = 0; i < 2; i++) begin : g_src
    hz_match #(.QUAL(Q_ANY))     u_id_ex_any (.i_slot(r_ex.base), .i_reg(w_id_rs[i]), .o_hit(w_id_ex_any[i]));
    hz_match #(.QUAL(Q_LOAD))    u_id_ex_ld  (.i_slot(r_ex.base), .i_reg(w_id_rs[i]), .o_hit(w_id_ex_ld[i]));
    hz_match #(.QUAL(Q_LOAD))    u_id_mem_ld (.i_slot(r_mem),     .i_reg(w_id_rs[i]), .o_hit(w_id_mem_ld[i]));
    hz_match #(.QUAL(Q_NONLOAD)) u_id_mem_nl (.i_slot(r_mem),     .i_reg(w_id_rs[i]), .o_hit(w_id_mem_nl[i]));
    hz_match #(.QUAL(Q_ANY))     u_id_wb     (.i_slot(r_wb),      .i_reg(w_id_rs[i]), .o_hit(w_id_wb[i]));
    hz_match #(.QUAL(Q_NONLOAD)) u_ex_mem_nl (.i_slot(r_mem),     .i_reg(w_ex_rs[i]), .o_hit(w_ex_mem_nl[i]));
    hz_match #(.QUAL(Q_ANY))     u_ex_wb     (.i_slot(r_wb),      .i_reg(w_ex_rs[i]), .o_hit(w_ex_wb[i]));

    assign w_fwd_ex[i] = w_ex_use[i] ? fwd_pick(w_ex_mem_nl[i], w_ex_wb[i]) : FWD_REG;
    assign w_bfwd[i]   = fwd_pick(w_id_mem_nl[i], w_id_wb[i]);
  end

  // A branch compares in decode, so any EX producer or a load still in MEM is too late to forward.
  assign w_ld_stall = |(w_id_use & w_id_ex_ld);
  assign w_br_stall = bus.id_branch & |(w_id_use & (w_id_ex_any | w_id_mem_ld));
  assign w_stall    = bus.id_valid & (w_ld_stall | w_br_stall);

  assign bus.freeze    = bus.mem_busy;
  assign bus.stall_fd  = w_stall & ~bus.mem_busy;
  assign bus.bubble_ex = w_stall & ~bus.mem_busy;
  assign bus.flush_d   = bus.jump & ~w_stall & ~bus.mem_busy;
  assign bus.fwd1_ex   = w_fwd_ex[0];
  assign bus.fwd2_ex   = w_fwd_ex[1];
  assign bus.bfwd1     = w_bfwd[0];
  assign bus.bfwd2     = w_bfwd[1];

  always_comb begin
    w_id_slot               = '0;
    w_id_slot.base.vld      = 1'b1;
    w_id_slot.base.rd       = bus.id_rd;
    w_id_slot.base.regwrite = bus.id_regwrite;
    w_id_slot.base.memread  = bus.id_memread;
    w_id_slot.rs1           = bus.id_rs1;
    w_id_slot.rs2           = bus.id_rs2;
    w_id_slot.use1          = bus.id_use_rs1;
    w_id_slot.use2          = bus.id_use_rs2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex.base;
      r_ex  <= (bus.id_valid && !w_stall) ? w_id_slot : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.stall_fd && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.flush_d && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised pipeline hazard and forwarding controller for the 5-stage CPU. It replaces the purely combinational forwarding unit. It keeps its own scoreboard of the EX, MEM and WB destination slots, and from that scoreboard it drives the forwarding selects, load-use and branch-operand stalls, the decode flush on jump, and a whole-pipeline freeze while the memory stage is busy. It sits beside the stage modules at CPU top level and is the single source of every stall, flush and forward control.

## Interface
- REG_AW, 3, register index width (2**REG_AW architectural registers, all writable).
- CNT_W, 16, width of the performance counters.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears the scoreboard and counters.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  decode source registers.
- id_use_rs1, id_use_rs2  in  1  the corresponding source is actually read.
- id_rd  in  REG_AW  decode destination.
- id_regwrite, id_memread  in  1  decode instruction writes a register / is a load.
- id_branch  in  1  decode instruction compares operands in decode (branch/jump-register).
- jump  in  1  decode requests a PC redirect this cycle.
- mem_busy  in  1  memory stage not ready; the whole pipeline must hold.
- stall_fd  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_d  out  1  replace the IF/ID contents with a NOP.
- freeze  out  1  all pipeline registers hold (equals mem_busy).
- fwd1_ex, fwd2_ex  out  2  EX operand select: 00 register file, 01 MEM ALU result, 10 WB data.
- bfwd1, bfwd2  out  2  decode comparator select, same encoding.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- The scoreboard has three slots, EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread}. The EX slot additionally holds rs1/rs2/use bits.
- Advance rule, when freeze=0:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes the decode fields when id_valid & !stall. Otherwise EX becomes invalid (bubble).
- When freeze=1, every slot holds.
- A slot "writes r" when it is valid, has regwrite set, and its rd equals r.
- EX forward, per operand, applied only when the use bit is set:
  - MEM slot writes r and is not a load: select 01.
  - Else WB slot writes r: select 10.
  - Else select 00.
  - MEM has priority over WB.
- Load-use stall (ld_stall): an ID source is in use and the EX slot writes it with memread set.
- Branch stall (br_stall): id_branch is set and either:
  - the EX slot writes a used source, or
  - the MEM slot writes a used source with memread set.
- stall = id_valid & (ld_stall | br_stall).
- When stall=1:
  - stall_fd=1 and bubble_ex=1.
  - flush_d=0.
  - jump is ignored that cycle.
- Decode comparator forward: MEM non-load writer selects 01, else WB writer selects 10, else 00.
- flush_d = jump & !stall & !freeze.
- Freeze precedence: freeze overrides everything. While freeze=1:
  - stall_fd=0, bubble_ex=0, flush_d=0.
  - Forward selects stay live, computed from the held slots.
- Register indices are compared over the full REG_AW bits. No register is treated as hardwired zero.

## Timing
- All control outputs are combinational from the current slots plus the ID inputs. There is zero-cycle latency to the stage muxes.
- The scoreboard and counters update on the rising clk edge.
- A load followed immediately by a dependent instruction gives exactly 1 stall cycle.
- A branch whose source is produced by an immediately preceding ALU op gives 1 stall cycle.
- A branch whose source is produced by an immediately preceding load gives 2 stall cycles.
- Reset values: all slots invalid. Therefore every fwd/bfwd output is 00, stall_fd=0, bubble_ex=0 and flush_d=0. freeze follows mem_busy. Counters are 0.
- Reset asserted mid-stall clears the scoreboard immediately. The stall drops in the same cycle.
- mem_busy arriving during a stall: the stall outputs deassert, the slots hold, and the stall re-evaluates identically once freeze drops.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on each cycle with stall=1 and freeze=0.
  - flush_cnt increments on each cycle with flush_d=1.
  - Both saturate at all-ones.
- HAZARD_PERF_EN not defined: counter registers are absent and stall_cnt and flush_cnt are tied to 0.

## Structure
- Package cpu_pkg holds:
  - the fwd_sel_t constants FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the slot struct typedef, parametrised by REG_AW through the package localparam.
- One sub-module, hz_match: slot-vs-register hit detection (valid, regwrite, rd compare, memread qualifier). It is instantiated per source/slot pair.

## Test plan
- Reset low, then release, no instructions: all fwd = 00, stall_fd=0, counters 0.
- ALU r1 ← r2+r3, then ALU using r1 as rs1: on the second instruction in EX, fwd1_ex=01. The next dependent instruction one further back gets fwd1_ex=10.
- Load r4, then add reading r4: stall_fd=1 and bubble_ex=1 for exactly 1 cycle, then fwd2_ex=10. stall_cnt=1.
- ALU r5, then branch on r5: 1 stall, then bfwd1=01. Load r5, then branch on r5: 2 stalls, then bfwd1=10.
- jump=1 with no hazard: flush_d=1 for 1 cycle and flush_cnt=1. The same jump during a load-use stall gives flush_d=0.
- mem_busy high for 3 cycles during a load-use stall: freeze=1, stall_fd=0 and the slots hold. After mem_busy drops, exactly 1 stall cycle follows and stall_cnt increases by 1.
